multiply: RTL
=============

MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 SHALL have parameter: bits, 16, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 SHALL have port: in1  input  bits  multiplicand, two's complement.
REQ-005 SHALL have port: in1_stb  input  1  in1 valid.
REQ-006 SHALL have port: in1_ack  output  1  ready to accept in1; registered.
REQ-007 SHALL have port: in2  input  bits  multiplier, two's complement.
REQ-008 SHALL have port: in2_stb  input  1  in2 valid.
REQ-009 SHALL have port: in2_ack  output  1  ready to accept in2; registered.
REQ-010 SHALL have port: out1  output  bits  product, low bits bits; registered.
REQ-011 SHALL have port: out1_stb  output  1  out1 valid; registered.
REQ-012 SHALL have port: out1_ack  input  1  consumer accepts out1.

Function
REQ-013 SHALL define a transfer on any port as stb=1 and ack=1 at the same rising edge; no other condition consumes or produces data.
REQ-014 SHALL implement three states: READ_A_B (collect operands), MULTIPLY (shift-add), WRITE_Z (present result).
REQ-015 In READ_A_B, each input SHALL be captured independently: in1_ack=1 until in1 transferred, then 0; same for in2.
REQ-016 The two operands may arrive on the same edge or on different edges, in either order; an operand already held SHALL NOT be overwritten.
REQ-017 On the edge E at which the second operand is held, the state SHALL become MULTIPLY; in1_ack and in2_ack SHALL be 0 from the cycle after E until the return to READ_A_B.
REQ-018 MULTIPLY SHALL perform exactly bits iterations, one per edge: if multiplier LSB=1, accumulator += multiplicand (mod 2^bits); then multiplicand shifts left 1 and multiplier shifts right 1 (logical).
REQ-019 The accumulator SHALL be cleared at E; after the final iteration, the state SHALL become WRITE_Z.
REQ-020 out1 SHALL equal (in1*in2) mod 2^bits, which is the correct two's-complement low half for signed and unsigned operands alike; overflow SHALL wrap silently.
REQ-021 out1_stb SHALL rise at edge E+bits+1, a fixed latency independent of operand values; zero operands SHALL NOT short-cut.
REQ-022 In WRITE_Z, out1 and out1_stb=1 SHALL hold stable until out1_ack=1 at an edge.
REQ-023 At the out1 transfer edge, out1_stb SHALL go 0, the state SHALL become READ_A_B, and in1_ack and in2_ack SHALL go 1 at that same edge.
REQ-024 in1_stb and in2_stb asserted during MULTIPLY or WRITE_Z SHALL be ignored, because ack=0; no operand is lost, since the producer holds stb.
REQ-025 The next operation SHALL NOT start until the previous result has been transferred, so at most one operation is in flight.

Reset
REQ-026 When rst=0 at an edge, the block SHALL enter READ_A_B with in1_ack=0, in2_ack=0, out1_stb=0, out1=0, held operands discarded, and accumulator and counter cleared.
REQ-027 Reset SHALL override all other actions in any state, including mid-MULTIPLY and during WRITE_Z with out1_stb=1; the pending result SHALL be dropped.
REQ-028 At the first edge with rst=1, in1_ack and in2_ack SHALL be set to 1, so the earliest operand transfer is the second edge after reset release.

Verification
REQ-029 Bench SHALL apply in1=3 and in2=5 on the same edge E, with out1_ack held 1 -> out1=15, out1_stb rising at E+17 (bits=16), high for exactly 1 cycle, then acks=1.
REQ-030 Bench SHALL apply in1=0xFFFF (-1) at edge t, then in2=0x0007 at t+4 -> in1_ack low from t+1, product 0xFFF9 (-7), stb at t+4+17.
REQ-031 Bench SHALL apply in1=0x8000 and in2=0xFFFF, then in1=0x0100 and in2=0x0100 -> results 0x8000 and 0x0000 (wrap), with latency identical for both.
REQ-032 Bench SHALL apply in1=1234 and in2=0 with out1_ack held 0 for 10 cycles -> out1=0 stable with out1_stb=1 throughout, and in1_stb/in2_stb presented meanwhile not acked; on the ack edge, stb=0 and acks=1.
REQ-033 Bench SHALL apply rst=0 for 1 edge at iteration 8 of MULTIPLY, then rst=1 -> out1_stb never rises for the aborted operation, acks=0 for 1 cycle then 1, and a fresh 6*7 yields 42.
REQ-034 Bench SHALL run 1000 random operand pairs with random stb and out1_ack gaps -> every out1 equals the reference (in1*in2) mod 2^16, with no lost or duplicated transfers.

Source files
------------

// File: rtl/multiply.sv
// Sequential shift-add multiplier with independent stb/ack handshakes on both
// operands and the result. Produces the low `bits` bits of in1*in2 after a
// fixed latency, with at most one operation in flight.
module multiply #(
    parameter int unsigned bits = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] in1,
    input  logic            in1_stb,
    output logic            in1_ack,
    input  logic [bits-1:0] in2,
    input  logic            in2_stb,
    output logic            in2_ack,
    output logic [bits-1:0] out1,
    output logic            out1_stb,
    input  logic            out1_ack
);

    localparam int unsigned CW = $clog2(bits) + 1;

    typedef enum logic [1:0] {
        READ_A_B,
        MULTIPLY,
        WRITE_Z
    } state_t;

    state_t          r_state;
    logic [bits-1:0] r_a;
    logic [bits-1:0] r_b;
    logic [bits-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_a_held;
    logic            r_b_held;

    state_t          w_state;
    logic [bits-1:0] w_a;
    logic [bits-1:0] w_b;
    logic [bits-1:0] w_acc;
    logic [CW-1:0]   w_cnt;
    logic            w_a_held;
    logic            w_b_held;
    logic            w_in1_ack;
    logic            w_in2_ack;
    logic [bits-1:0] w_out1;
    logic            w_out1_stb;

    logic            w_xfer1;
    logic            w_xfer2;

    assign w_xfer1 = in1_stb & in1_ack;
    assign w_xfer2 = in2_stb & in2_ack;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state    = r_state;
        w_a        = r_a;
        w_b        = r_b;
        w_acc      = r_acc;
        w_cnt      = r_cnt;
        w_a_held   = r_a_held;
        w_b_held   = r_b_held;
        w_in1_ack  = 1'b0;
        w_in2_ack  = 1'b0;
        w_out1     = out1;
        w_out1_stb = out1_stb;

        case (r_state)
            READ_A_B: begin
                if (w_xfer1) begin
                    w_a      = in1;
                    w_a_held = 1'b1;
                end
                if (w_xfer2) begin
                    w_b      = in2;
                    w_b_held = 1'b1;
                end
                if (w_a_held && w_b_held) begin
                    // Both operands present: start a fresh accumulation.
                    w_state  = MULTIPLY;
                    w_acc    = '0;
                    w_cnt    = '0;
                    w_a_held = 1'b0;
                    w_b_held = 1'b0;
                end else begin
                    // Keep offering only the operands not yet captured.
                    w_in1_ack = ~w_a_held;
                    w_in2_ack = ~w_b_held;
                end
            end

            MULTIPLY: begin
                // One shift-add step per edge; no early exit on zero operands.
                if (r_b[0]) begin
                    w_acc = r_acc + r_a;
                end
                w_a   = r_a << 1;
                w_b   = r_b >> 1;
                w_cnt = r_cnt + CW'(1);
                if (r_cnt == CW'(bits - 1)) begin
                    w_state = WRITE_Z;
                end
            end

            WRITE_Z: begin
                if (!out1_stb) begin
                    w_out1     = r_acc;
                    w_out1_stb = 1'b1;
                end else if (out1_ack) begin
                    w_out1_stb = 1'b0;
                    w_state    = READ_A_B;
                    w_in1_ack  = 1'b1;
                    w_in2_ack  = 1'b1;
                end
            end

            default: begin
                w_state = READ_A_B;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= READ_A_B;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_a_held <= 1'b0;
            r_b_held <= 1'b0;
            in1_ack  <= 1'b0;
            in2_ack  <= 1'b0;
            out1     <= '0;
            out1_stb <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_b      <= w_b;
            r_acc    <= w_acc;
            r_cnt    <= w_cnt;
            r_a_held <= w_a_held;
            r_b_held <= w_b_held;
            in1_ack  <= w_in1_ack;
            in2_ack  <= w_in2_ack;
            out1     <= w_out1;
            out1_stb <= w_out1_stb;
        end
    end

endmodule
